// File: rtl/audio_capture_pkg.sv
// Shared definitions for the audio capture path: sample format, FSM encoding
// and capture-region sizing also used by the playback module.
package audio_capture_pkg;

  localparam int SAMPLE_W           = 6;
  localparam int SAMPLE_MSB         = 31;
  localparam int SAMPLE_LSB         = 26;
  localparam int MAG_W              = 5;
  localparam int CAPTURE_DEPTH_LOG2 = 14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_DONE   = 2'd2
  } cap_state_e;

  // |s| of a 6-bit two's-complement sample; -32 saturates to 31.
  function automatic logic [MAG_W-1:0] sample_mag(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] a;
    a = s[SAMPLE_W-1] ? (~s + 6'd1) : s;
    return a[SAMPLE_W-1] ? 5'd31 : a[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/audio_capture_hit_detect.sv
// Loud-sample detector: magnitude against threshold, with a holdoff window
// counted in accepted samples after each hit.
module audio_hit_detect
  import audio_capture_pkg::*;
#(
  parameter int HOLDOFF = 4800
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                accept,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [MAG_W-1:0]    threshold,
  output logic                hit
);

  localparam int HO_W = $clog2(HOLDOFF + 2);

  logic [HO_W-1:0]  holdoff_cnt;
  logic [MAG_W-1:0] mag;

  assign mag = sample_mag(sample);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hit         <= 1'b0;
      holdoff_cnt <= '0;
    end else begin
      hit <= 1'b0;
      if (accept) begin
        if (holdoff_cnt == '0) begin
          if (mag >= threshold) begin
            hit         <= 1'b1;
            holdoff_cnt <= HO_W'(HOLDOFF);
          end
        end else begin
          holdoff_cnt <= holdoff_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/audio_capture.sv
// Microphone capture: pops samples from the Audio_Controller, decimates them
// into an external buffer RAM and flags loud samples.
module audio_capture
  import audio_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = CAPTURE_DEPTH_LOG2,
  parameter int DECIM      = 4,
  parameter int HOLDOFF    = 4800
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  audio_in_available,
  input  logic [31:0]           left_channel_audio_in,
  output logic                  read_audio_in,
  input  logic                  record_start,
  input  logic [MAG_W-1:0]      threshold,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [SAMPLE_W-1:0]   wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  hit,
  output cap_state_e            debug_state
);

  // Handshake: a sample pair is taken on every cycle where audio_in_available
  // is high outside reset; read_audio_in mirrors that and pops the pair.
  cap_state_e          state, state_nxt;
  logic                accept;
  logic                start_cap;
  logic                store;
  logic                last_write;
  logic [7:0]          dec_cnt;
  logic [SAMPLE_W-1:0] sample;
  logic                unused_low_bits;

  assign accept          = audio_in_available & ~reset;
  assign read_audio_in   = accept;
  assign sample          = left_channel_audio_in[SAMPLE_MSB:SAMPLE_LSB];
  assign unused_low_bits = ^left_channel_audio_in[SAMPLE_LSB-1:0];
  assign last_write      = wr_en && (wr_addr == '1);
  assign busy            = (state == ST_RECORD);
  assign done            = (state == ST_DONE);
  assign debug_state     = state;

  always_comb begin
    state_nxt = state;
    start_cap = 1'b0;
    store     = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (record_start) begin
          state_nxt = ST_RECORD;
          start_cap = 1'b1;
        end
      end
      ST_RECORD: begin
        // The final write closes the capture; nothing accepted alongside it is kept.
        if (last_write) state_nxt = ST_DONE;
        else if (accept && dec_cnt == 8'd0) store = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
      wr_addr <= '0;
      dec_cnt <= '0;
    end else begin
      wr_en <= store;
      if (store) wr_data <= sample;
      if (start_cap) begin
        wr_addr <= '0;
        dec_cnt <= '0;
      end else if (state == ST_RECORD) begin
        if (wr_en) wr_addr <= wr_addr + 1'b1;
        if (accept) dec_cnt <= (dec_cnt == 8'(DECIM - 1)) ? 8'd0 : dec_cnt + 8'd1;
      end
    end
  end

  audio_hit_detect #(.HOLDOFF(HOLDOFF)) u_hit (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .accept    (accept),
    .sample    (sample),
    .threshold (threshold),
    .hit       (hit)
  );

endmodule

// File: doc/audio_capture.md
AUDIO_CAPTURE -- requirements
Module: audio_capture

Interface
REQ-001 Parameter DEPTH_LOG2, 14, log2 of capture buffer depth in words.
REQ-002 Parameter DECIM, 4, store one of every DECIM accepted samples (range 1..255).
REQ-003 Parameter HOLDOFF, 4800, accepted samples ignored after a hit.
REQ-004 CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 audio_in_available  in  1  Audio_Controller has a sample pair ready.
REQ-007 left_channel_audio_in  in  32  mic sample; bits [31:26] used.
REQ-008 read_audio_in  out  1  pops one sample pair from the Audio_Controller.
REQ-009 record_start  in  1  one-cycle request to begin a capture.
REQ-010 threshold  in  5  hit magnitude threshold, 0..31.
REQ-011 wr_en  out  1  buffer RAM write strobe.
REQ-012 wr_addr  out  DEPTH_LOG2  buffer RAM write address.
REQ-013 wr_data  out  6  signed sample in the same format the playback path reads from ROM.
REQ-014 busy  out  1  capture in progress.
REQ-015 done  out  1  buffer full, capture complete.
REQ-016 hit  out  1  one-cycle pulse on a loud sample.

Function
REQ-017 read_audio_in SHALL equal audio_in_available whenever reset is low; a sample is "accepted" on each cycle where both are high.
REQ-018 The accepted sample SHALL be s = left_channel_audio_in[31:26], a 6-bit two's-complement value.
REQ-019 Magnitude SHALL be |s|, saturated to 31 (s = -32 gives 31).
REQ-020 The FSM SHALL have the states IDLE, RECORD and DONE; busy is 1 only in RECORD, and done is 1 only in DONE.
REQ-021 A record_start in IDLE or DONE SHALL cause the next state RECORD, wr_addr 0 and decimation counter 0; a record_start in RECORD SHALL be ignored.
REQ-022 A sample accepted in the same cycle as a record_start SHALL NOT be stored; the first accepted sample after that cycle SHALL be stored.
REQ-023 In RECORD, the decimation counter SHALL increment on each accepted sample and wrap at DECIM-1; the sample is stored when the counter is 0.
REQ-024 A store SHALL assert wr_en for exactly one cycle, in the cycle after acceptance, with wr_data = s and wr_addr = the current address; the address SHALL increment after the write.
REQ-025 The write to address 2^DEPTH_LOG2-1 SHALL cause the transition to DONE in the same edge; wr_addr SHALL wrap to 0; no further writes SHALL occur.
REQ-026 Hit detection SHALL run in every FSM state: an accepted sample with magnitude >= threshold and holdoff counter = 0 SHALL pulse hit one cycle after acceptance and load the holdoff counter with HOLDOFF.
REQ-027 The holdoff counter SHALL decrement only on accepted samples and SHALL saturate at 0; a qualifying sample during holdoff SHALL NOT produce a hit.
REQ-028 threshold = 0 SHALL make every accepted sample outside holdoff a hit.
REQ-029 Outputs wr_en and hit SHALL be registered; read_audio_in is the only combinational output.

Reset
REQ-030 When reset is high, SHALL force FSM to IDLE, wr_addr=0, wr_data=0, wr_en=0, hit=0, busy=0, done=0, decimation and holdoff counters to 0, read_audio_in=0.
REQ-031 Reset SHALL win over record_start and sample acceptance in the same cycle.
REQ-032 Reset mid-RECORD SHALL abandon the capture with no further writes; buffer contents are undefined.

Structure
REQ-033 The shared package SHALL hold sample width (6), sample slice MSB/LSB (31/26), FSM state encoding, and the capture-region constants shared with the playback module.
REQ-034 The magnitude, threshold compare and holdoff counter SHALL form one sub-module, audio_hit_detect, whose interface is accept, sample, threshold and hit.
REQ-035 The RAM SHALL sit outside this block.

Verification
REQ-036 With DEPTH_LOG2=4 and DECIM=1, a record_start followed by 16 accepted samples 0..15 SHALL produce 16 wr_en pulses at addresses 0..15 with matching data; done=1 after the 16th and no 17th write.
REQ-037 With DECIM=4, 12 accepted samples after start SHALL produce writes of samples #0, #4 and #8 only, at addresses 0, 1 and 2.
REQ-038 With threshold=20 and HOLDOFF=3, the sample sequence +25, -30, 0, 0, -21 SHALL give exactly 2 hit pulses, on the 1st and 5th samples; s=-32 with threshold=31 SHALL give a hit.
REQ-039 A record_start coincident with an accepted sample, and a second record_start mid-RECORD, SHALL leave the first stored sample as the next accepted one with the address sequence unbroken.
REQ-040 Reset asserted after 5 writes in RECORD SHALL give busy=0, wr_addr=0 and no wr_en on the next cycle; a new record_start SHALL restart from address 0.
REQ-041 audio_in_available held high for 10 cycles SHALL give read_audio_in high for 10 cycles; with reset high, read_audio_in SHALL be 0.
